key_event_ctrl: RTL and testbench
=================================

// Module: key_event_ctrl
// PURPOSE
//  Memory-mapped push-button controller for the riscvmulti I/O space. The top-level address decode selects it.
//  Synchronises and debounces NKEYS active-low keys, then latches press events into sticky flags.
//  The CPU polls the flags and clears them with write-1-to-clear. Replaces raw KEY reads on the IO_KEY address.
// PARAMETERS
//  NKEYS     4  number of keys handled (1..8)
//  DEB_CYC   4  stable cycles required before a level change is accepted (>=2)
//  CNT_W     $clog2(DEB_CYC+1)  debounce counter width (derived; do not override)
// PORTS
//  clk       in   1      system clock (CPU clock domain); one clock only
//  reset     in   1      synchronous, active-low reset (asserted when 0)
//  key_n     in   NKEYS  raw keys, 0 = pressed, asynchronous to clk
//  sel       in   1      I/O access targets this block (decoded in top)
//  we        in   1      write strobe, valid with sel
//  offset    in   2      register select: 0 LEVEL, 1 EVENT, 2 OVERRUN, 3 MASK
//  wdata     in   32     write data
//  rdata     out  32     read data, combinational from offset; upper bits are 0
//  irq       out  1      only with KEY_IRQ_EN; OR of (EVENT & MASK)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): sync flops = released; FSMs = REL; counters = 0; LEVEL/EVENT/OVERRUN/MASK = 0; irq = 0.
//    A reset mid-debounce discards the partial count.
//  - Sync: key_n inverted, passed through 2 flops per key. The pressed level appears in sync[i] 2 cycles after the pin.
//  - FSM per key: REL -> PWAIT when sync=1; PWAIT counts cycles with sync=1.
//    PWAIT -> PRS when cnt reaches DEB_CYC-1; PWAIT -> REL (cnt=0) on any sync=0.
//    PRS -> RWAIT when sync=0; RWAIT -> REL after DEB_CYC-1 counts; RWAIT -> PRS on any sync=1.
//    The counter never wraps: it clears on every state entry.
//  - LEVEL[i] = 1 in PRS and RWAIT, else 0.
//  - Event: the cycle PWAIT->PRS fires sets EVENT[i]. If EVENT[i] was already 1, OVERRUN[i] is set as well.
//    Release generates no event.
//  - Latency: a clean press stable from cycle 0 sets EVENT[i] visibly at cycle 2+DEB_CYC.
//  - Writes (sel&we, posedge): offset1: EVENT &= ~wdata[NKEYS-1:0]; offset2: same for OVERRUN.
//    offset0 write is ignored. Bits >= NKEYS are ignored.
//  - Simultaneous set and W1C on the same bit in the same cycle: set wins (bit stays 1).
//    OVERRUN is not set by that collision.
//  - Reads: side-effect free. rdata = 0 when sel=0.
//  - No handshake. Single-cycle access; a write takes effect at the next posedge.
// CONFIGURATION
//  KEY_IRQ_EN defined: offset3 is MASK (RW, reset 0); irq = |(EVENT & MASK), registered (1 cycle after EVENT/MASK).
//  KEY_IRQ_EN undefined: no irq port, no MASK register; offset3 reads 0, writes ignored.
// STRUCTURE
//  Package key_event_pkg:
//   - typedef enum logic [1:0] {REL, PWAIT, PRS, RWAIT} deb_state_t
//   - localparams OFF_LEVEL=0, OFF_EVENT=1, OFF_OVERRUN=2, OFF_MASK=3
//  Sub-module key_debounce: one key's sync + FSM + counter; outputs level and a press pulse.
//   Instantiated NKEYS times via generate.
//  key_event_ctrl owns the EVENT/OVERRUN/MASK registers, read mux and irq.
// TESTING (DEB_CYC=4, NKEYS=4)
//  1 reset=0 for 2 cycles with keys pressed -> rdata 0 at all offsets, irq=0; after release of reset, no events until debounce completes.
//  2 key_n[1] low, stable 10 cycles -> EVENT=0x2 at cycle 6, LEVEL=0x2; key_n[1] high 6 cycles -> LEVEL=0, EVENT still 0x2.
//  3 key_n[0] toggles every 2 cycles for 20 cycles -> EVENT=0, LEVEL=0 throughout.
//  4 two clean presses of key 2 without clearing -> EVENT=0x4, OVERRUN=0x4; write 0x4 to offset1 and offset2 -> both 0.
//  5 W1C of EVENT[3] in the exact set cycle -> EVENT[3]=1 afterwards, OVERRUN[3]=0.
//  6 KEY_IRQ_EN: MASK=0x1, press key 1 -> irq stays 0; press key 0 -> irq=1 one cycle after EVENT[0]; W1C 0x1 -> irq=0 next cycle.

Source files
------------

// File: rtl/key_event_pkg.sv
// key_event_pkg: shared debounce state encoding and register offsets for key_event_ctrl.
package key_event_pkg;
   typedef enum logic [1:0] {REL, PWAIT, PRS, RWAIT} deb_state_t;
   localparam logic [1:0] OFF_LEVEL   = 2'd0;
   localparam logic [1:0] OFF_EVENT   = 2'd1;
   localparam logic [1:0] OFF_OVERRUN = 2'd2;
   localparam logic [1:0] OFF_MASK    = 2'd3;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: one key's two-flop synchroniser, debounce FSM and counter.
// Emits the debounced level and a one-cycle press pulse on PWAIT->PRS.
module key_debounce
   import key_event_pkg::*;
#(
   parameter int DEB_CYC = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic level,
   output logic press
);
   localparam int CNT_W = $clog2(DEB_CYC + 1);
   logic [1:0] sync;
   deb_state_t state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic last;
   // the entry cycle counts as the first stable cycle, so the final count is DEB_CYC-2
   assign last = cnt == CNT_W'(DEB_CYC - 2);
   always_ff @(posedge clk)
      if (!reset) begin
         sync  <= '0;
         state <= REL;
         cnt   <= '0;
      end else begin
         sync  <= {sync[0], ~key_n};
         state <= state_next;
         cnt   <= cnt_next;
      end
   always_comb begin
      state_next = state;
      case (state)
         REL:     state_next = sync[1] ? PWAIT : REL;
         PWAIT:   state_next = !sync[1] ? REL : last ? PRS : PWAIT;
         PRS:     state_next = sync[1] ? PRS : RWAIT;
         RWAIT:   state_next = sync[1] ? PRS : last ? REL : RWAIT;
         default: state_next = REL;
      endcase
      cnt_next = (state_next == state && (state == PWAIT || state == RWAIT)) ? cnt + 1'b1 : '0;
   end
   always_comb begin
      level = state == PRS || state == RWAIT;
      press = state == PWAIT && sync[1] && last;
   end
endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounced push-button event flags with W1C clear, memory-mapped.
// Define KEY_IRQ_EN to add the MASK register and the registered irq output.
module key_event_ctrl
   import key_event_pkg::*;
#(
   parameter int NKEYS   = 4,
   parameter int DEB_CYC = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NKEYS-1:0] key_n,
   input  logic             sel,
   input  logic             we,
   input  logic [1:0]       offset,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
`ifdef KEY_IRQ_EN
   ,
   output logic             irq
`endif
);
   logic [NKEYS-1:0] level, press, evt, ovr, clr_ev, clr_ov, mask_rd, rsel;
   genvar i;
   generate
      for (i = 0; i < NKEYS; i++) begin : g_key
         key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk   (clk),
            .reset (reset),
            .key_n (key_n[i]),
            .level (level[i]),
            .press (press[i])
         );
      end
   endgenerate
   assign clr_ev = (sel && we && offset == OFF_EVENT)   ? wdata[NKEYS-1:0] : '0;
   assign clr_ov = (sel && we && offset == OFF_OVERRUN) ? wdata[NKEYS-1:0] : '0;
   // set is ORed in after the clear so a same-cycle press wins over W1C
   always_ff @(posedge clk)
      if (!reset) begin
         evt <= '0;
         ovr <= '0;
      end else begin
         evt <= (evt & ~clr_ev) | press;
         ovr <= (ovr & ~clr_ov) | (press & evt);
      end
`ifdef KEY_IRQ_EN
   logic [NKEYS-1:0] msk;
   always_ff @(posedge clk)
      if (!reset) begin
         msk <= '0;
         irq <= 1'b0;
      end else begin
         if (sel && we && offset == OFF_MASK) msk <= wdata[NKEYS-1:0];
         irq <= |(evt & msk);
      end
   assign mask_rd = msk;
`else
   assign mask_rd = '0;
`endif
   always_comb begin
      rsel  = offset == OFF_LEVEL ? level : offset == OFF_EVENT ? evt :
              offset == OFF_OVERRUN ? ovr : mask_rd;
      rdata = sel ? 32'(rsel) : 32'd0;
   end
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed self-checking bench for key_event_ctrl (NKEYS=4, DEB_CYC=4).
module tb_key_event_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  key_n = 4'hF;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  offset = 2'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
`ifdef KEY_IRQ_EN
   logic        irq;
`endif
   int n_checks = 0;
   int n_fail = 0;

   key_event_ctrl #(.NKEYS(4), .DEB_CYC(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .key_n  (key_n),
      .sel    (sel),
      .we     (we),
      .offset (offset),
      .wdata  (wdata),
      .rdata  (rdata)
`ifdef KEY_IRQ_EN
      ,
      .irq    (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input logic [1:0] off, output logic [31:0] d);
      sel = 1'b1;
      we = 1'b0;
      offset = off;
      #1;
      d = rdata;
      sel = 1'b0;
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] d);
      sel = 1'b1;
      we = 1'b1;
      offset = off;
      wdata = d;
      @(posedge clk);
      #1;
      sel = 1'b0;
      we = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset = 1'b0;
      key_n = 4'h0;
      tick(2);
      for (int o = 0; o < 4; o++) begin
         rd(2'(o), d);
         n_checks++;
         if (d !== 32'd0) begin
            $display("FAIL reset_rd off%0d got=%h exp=%h", o, d, 32'd0);
            n_fail++;
         end
      end
      sel = 1'b0;
      #1;
      n_checks++;
      if (rdata !== 32'd0) begin
         $display("FAIL unselected_rd got=%h exp=%h", rdata, 32'd0);
         n_fail++;
      end
`ifdef KEY_IRQ_EN
      n_checks++;
      if (irq !== 1'b0) begin
         $display("FAIL reset_irq got=%b exp=0", irq);
         n_fail++;
      end
`endif
      reset = 1'b1;
      tick(5);
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'd0) begin
         $display("FAIL reset_early_event got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
      tick(1);
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'hF) begin
         $display("FAIL reset_debounced_event got=%h exp=%h", d, 32'hF);
         n_fail++;
      end
      key_n = 4'hF;
      tick(8);
      wr(2'd1, 32'hF);
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'd0) begin
         $display("FAIL reset_clear_event got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
   endtask

   task automatic test_clean_press;
      logic [31:0] d;
      key_n = 4'b1101;
      tick(5);
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'd0) begin
         $display("FAIL press_cycle5_event got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
      tick(1);
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'h2) begin
         $display("FAIL press_cycle6_event got=%h exp=%h", d, 32'h2);
         n_fail++;
      end
      rd(2'd0, d);
      n_checks++;
      if (d !== 32'h2) begin
         $display("FAIL press_level got=%h exp=%h", d, 32'h2);
         n_fail++;
      end
      tick(4);
      key_n = 4'hF;
      tick(5);
      rd(2'd0, d);
      n_checks++;
      if (d !== 32'h2) begin
         $display("FAIL release_level_held got=%h exp=%h", d, 32'h2);
         n_fail++;
      end
      tick(1);
      rd(2'd0, d);
      n_checks++;
      if (d !== 32'd0) begin
         $display("FAIL release_level got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'h2) begin
         $display("FAIL release_event_sticky got=%h exp=%h", d, 32'h2);
         n_fail++;
      end
      wr(2'd0, 32'hF);
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'h2) begin
         $display("FAIL level_write_ignored got=%h exp=%h", d, 32'h2);
         n_fail++;
      end
      wr(2'd1, 32'h2);
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'd0) begin
         $display("FAIL press_w1c got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
   endtask

   task automatic test_bounce;
      logic [31:0] d;
      logic [31:0] e;
      int bad;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         key_n[0] = (c % 4) < 2 ? 1'b0 : 1'b1;
         tick(1);
         rd(2'd1, d);
         rd(2'd0, e);
         if (d !== 32'd0 || e !== 32'd0) bad++;
      end
      key_n = 4'hF;
      tick(6);
      rd(2'd1, d);
      n_checks++;
      if (bad != 0) begin
         $display("FAIL bounce_window got=%0d bad cycles exp=0", bad);
         n_fail++;
      end
      n_checks++;
      if (d !== 32'd0) begin
         $display("FAIL bounce_event got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
   endtask

   task automatic test_overrun;
      logic [31:0] d;
      for (int p = 0; p < 2; p++) begin
         key_n = 4'b1011;
         tick(8);
         key_n = 4'hF;
         tick(8);
      end
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'h4) begin
         $display("FAIL overrun_event got=%h exp=%h", d, 32'h4);
         n_fail++;
      end
      rd(2'd2, d);
      n_checks++;
      if (d !== 32'h4) begin
         $display("FAIL overrun_flag got=%h exp=%h", d, 32'h4);
         n_fail++;
      end
      wr(2'd1, 32'hFFFF_FFF0);
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'h4) begin
         $display("FAIL upper_bits_ignored got=%h exp=%h", d, 32'h4);
         n_fail++;
      end
      wr(2'd1, 32'h4);
      wr(2'd2, 32'h4);
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'd0) begin
         $display("FAIL overrun_clear_event got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
      rd(2'd2, d);
      n_checks++;
      if (d !== 32'd0) begin
         $display("FAIL overrun_clear_flag got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
   endtask

   task automatic test_collision;
      logic [31:0] d;
      key_n = 4'b0111;
      tick(5);
      wr(2'd1, 32'h8);
      rd(2'd1, d);
      n_checks++;
      if (d !== 32'h8) begin
         $display("FAIL collision_event got=%h exp=%h", d, 32'h8);
         n_fail++;
      end
      rd(2'd2, d);
      n_checks++;
      if (d !== 32'd0) begin
         $display("FAIL collision_overrun got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
      key_n = 4'hF;
      tick(8);
      wr(2'd1, 32'h8);
      rd(2'd3, d);
      n_checks++;
`ifdef KEY_IRQ_EN
      if (d !== 32'd0) begin
         $display("FAIL mask_reset got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
`else
      if (d !== 32'd0) begin
         $display("FAIL offset3_read got=%h exp=%h", d, 32'd0);
         n_fail++;
      end
`endif
   endtask

`ifdef KEY_IRQ_EN
   task automatic test_irq;
      logic [31:0] d;
      wr(2'd3, 32'h1);
      rd(2'd3, d);
      n_checks++;
      if (d !== 32'h1) begin
         $display("FAIL mask_rd got=%h exp=%h", d, 32'h1);
         n_fail++;
      end
      key_n = 4'b1101;
      tick(8);
      n_checks++;
      if (irq !== 1'b0) begin
         $display("FAIL irq_masked got=%b exp=0", irq);
         n_fail++;
      end
      key_n = 4'hF;
      tick(8);
      key_n = 4'b1110;
      tick(6);
      n_checks++;
      if (irq !== 1'b0) begin
         $display("FAIL irq_early got=%b exp=0", irq);
         n_fail++;
      end
      tick(1);
      n_checks++;
      if (irq !== 1'b1) begin
         $display("FAIL irq_set got=%b exp=1", irq);
         n_fail++;
      end
      wr(2'd1, 32'h1);
      tick(1);
      n_checks++;
      if (irq !== 1'b0) begin
         $display("FAIL irq_clear got=%b exp=0", irq);
         n_fail++;
      end
      key_n = 4'hF;
      tick(8);
   endtask
`endif

   initial begin
      test_reset;
      test_clean_press;
      test_bounce;
      test_overrun;
      test_collision;
`ifdef KEY_IRQ_EN
      test_irq;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
